mips_run_monitor: RTL and testbench
===================================

# mips_run_monitor

Synthesizable run controller and monitor for the MIPS core. It drives the core's reset, sequences a run on a `start` pulse, and watches the `PC`/`instruction` buses. It ends the run on halt (jump-to-self), timeout or abort, and keeps a circular trace of the last samples for readback. It sits between the simulation/FPGA harness and the `mips` top level, and replaces hand-timed reset and fixed-length runs.

## Interface
- `DATA_W`, 32: width of `PC`, `instruction`, trace outputs.
- `RESET_CYCLES`, 2: cycles `cpu_reset` is held high at run start (≥1).
- `TIMEOUT`, 1000: max RUN samples before timeout (≥1, < 2^32).
- `HALT_REPEAT`, 3: consecutive repeated-PC samples that count as halt (≥1).
- `TRACE_DEPTH`, 16: trace entries, power of two ≥2; `TW = log2(TRACE_DEPTH)`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- `abort` in 1: ends an active run (RESET_HOLD or RUN).
- `PC` in DATA_W: core program counter.
- `instruction` in DATA_W: core fetched instruction.
- `cpu_reset` out 1: reset to the core, active-high.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `status` out 2: 00 none, 01 halted, 10 timeout, 11 aborted.
- `cycle_count` out 32: RUN samples taken in the current/last run.
- `trace_addr` in TW: trace index, 0 = oldest.
- `trace_pc` out DATA_W, `trace_instr` out DATA_W: registered trace read data.
- `trace_count` out TW+1: valid entries, saturates at TRACE_DEPTH.

## Operation
- FSM states: IDLE, RESET_HOLD, RUN, DONE.
- IDLE: `cpu_reset`=1, core held in reset. `start` → RESET_HOLD.
- On entry to RESET_HOLD: clear `cycle_count`, `trace_count`, write pointer, repeat counter, `status`.
- RESET_HOLD: `cpu_reset`=1 for exactly RESET_CYCLES cycles, then → RUN.
- RUN: `cpu_reset`=0. Each edge samples `PC`/`instruction`: `cycle_count`+1, trace write at pointer, pointer+1 mod depth, `trace_count` saturating +1.
- Halt detection: `prev_pc` is registered each sample. The repeat counter increments when `PC==prev_pc` and clears otherwise. The first RUN sample has no valid `prev_pc`, so the counter is 0. The counter reaching HALT_REPEAT → DONE with status 01.
- Timeout: the sample that makes `cycle_count`==TIMEOUT → DONE with status 10, unless halt fires on the same sample (halt wins).
- Abort: `abort` in RESET_HOLD/RUN → DONE with status 11. The sample on that edge is not taken. Abort has priority over halt/timeout on the same edge.
- DONE: `cpu_reset`=1; `cycle_count`, `status`, trace frozen and readable. `start` → RESET_HOLD (new run).
- Trace read: entry index = (wr_ptr − trace_count + trace_addr) mod TRACE_DEPTH. If `trace_addr` ≥ `trace_count`, the outputs are 0. Reads are valid in any state.
- Width: `cycle_count` cannot wrap because TIMEOUT < 2^32; pointer arithmetic is modulo TRACE_DEPTH.

## Timing
- Reset values:
  - state IDLE, `cpu_reset`=1
  - `running`=0, `done`=0, `status`=00
  - `cycle_count`=0, `trace_count`=0
  - `trace_pc`=0, `trace_instr`=0
  - Trace memory contents are don't-care.
- `reset` asserted mid-run: all of the above take effect immediately, asynchronously. Release is sampled on the next rising edge; the block stays in IDLE until `start`.
- `start` at edge N → `cpu_reset` high on edges N+1..N+RESET_CYCLES. The first RUN sample is at edge N+RESET_CYCLES+1.
- All outputs are registered. `done`/`status` are visible after the edge that takes the terminating sample.
- Trace read latency is 1 cycle from `trace_addr`.

## Test plan
- Halt: RESET_CYCLES=2, HALT_REPEAT=3, PC sequence 0,4,8,8,8,8 → after 6th sample `done`=1, `status`=01, `cycle_count`=6, `cpu_reset`=1.
- Timeout: TIMEOUT=20, PC increments by 4 each cycle → `status`=10, `cycle_count`=20, `running` falls the same edge.
- Trace wrap: TRACE_DEPTH=8, TIMEOUT=12, PC=0,4,…,44 → `trace_count`=8; `trace_addr`=0 gives `trace_pc`=16; addr 7 gives 44; `trace_instr` matches the paired values.
- Simultaneous: TIMEOUT=6 with the halt sequence → `status`=01 (halt wins), `cycle_count`=6. Abort on the same edge instead → `status`=11, `cycle_count`=5.
- Reset mid-run: assert `reset` at the 5th RUN sample, between edges → outputs reset immediately, `cpu_reset`=1. A new `start` then runs cleanly from `cycle_count`=0.
- Restart: `start` in DONE after a timeout → `status`=00, `trace_count`=0, `cpu_reset` high for RESET_CYCLES, then RUN.

Source files
------------

// File: rtl/mips_run_monitor.sv
// Run controller for the MIPS core: sequences core reset, runs until halt
// (jump-to-self), timeout or abort, and keeps a circular PC/instruction trace.
module mips_run_monitor #(
    parameter int DATA_W       = 32,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1000,
    parameter int HALT_REPEAT  = 3,
    parameter int TRACE_DEPTH  = 16,
    localparam int TW          = $clog2(TRACE_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] instruction,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [31:0]       cycle_count,
    input  logic [TW-1:0]     trace_addr,
    output logic [DATA_W-1:0] trace_pc,
    output logic [DATA_W-1:0] trace_instr,
    output logic [TW:0]       trace_count,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    localparam logic [TW:0]  TRACE_FULL = (TW+1)'(TRACE_DEPTH);
    localparam logic [31:0]  HOLD_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]  HALT_LIMIT = 32'(HALT_REPEAT);
    localparam logic [31:0]  TIME_LIMIT = 32'(TIMEOUT);

    state_t            state;
    logic [31:0]       hold_cnt;
    logic [31:0]       rep_cnt;
    logic [DATA_W-1:0] prev_pc;
    logic [TW-1:0]     wr_ptr;

    logic [DATA_W-1:0] mem_pc    [TRACE_DEPTH];
    logic [DATA_W-1:0] mem_instr [TRACE_DEPTH];

    logic              take_sample;
    logic [31:0]       next_count;
    logic [31:0]       next_rep;
    logic              halt_hit;
    logic              timeout_hit;
    logic [TW-1:0]     rd_idx;
    logic              rd_valid;

    // The first sample of a run has no predecessor, so it can never extend a repeat.
    always_comb begin
        take_sample = (state == RUN) && !abort;
        next_count  = cycle_count + 32'd1;
        next_rep    = '0;
        if ((cycle_count != 32'd0) && (PC == prev_pc))
            next_rep = rep_cnt + 32'd1;
        halt_hit    = (next_rep == HALT_LIMIT);
        timeout_hit = (next_count == TIME_LIMIT);
        rd_idx      = wr_ptr - trace_count[TW-1:0] + trace_addr;
        rd_valid    = ({1'b0, trace_addr} < trace_count);
    end

    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            cycle_count <= '0;
            trace_count <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            prev_pc     <= '0;
            wr_ptr      <= '0;
            trace_pc    <= '0;
            trace_instr <= '0;
        end else begin
            trace_pc    <= rd_valid ? mem_pc[rd_idx]    : '0;
            trace_instr <= rd_valid ? mem_instr[rd_idx] : '0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RESET_HOLD;
                        cpu_reset   <= 1'b1;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        status      <= ST_NONE;
                        cycle_count <= '0;
                        trace_count <= '0;
                        hold_cnt    <= '0;
                        rep_cnt     <= '0;
                        wr_ptr      <= '0;
                    end
                end

                RESET_HOLD: begin
                    if (abort) begin
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        status    <= ST_ABORTED;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + 32'd1;
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Aborting edge discards its sample entirely.
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        status    <= ST_ABORTED;
                    end else begin
                        cycle_count <= next_count;
                        wr_ptr      <= wr_ptr + 1'b1;
                        prev_pc     <= PC;
                        rep_cnt     <= next_rep;
                        if (trace_count != TRACE_FULL)
                            trace_count <= trace_count + 1'b1;
                        if (halt_hit || timeout_hit) begin
                            state     <= DONE;
                            cpu_reset <= 1'b1;
                            running   <= 1'b0;
                            done      <= 1'b1;
                            status    <= halt_hit ? ST_HALTED : ST_TIMEOUT;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Trace storage carries no reset; unwritten entries are masked by trace_count.
    always_ff @(posedge clock) begin
        if (take_sample) begin
            mem_pc[wr_ptr]    <= PC;
            mem_instr[wr_ptr] <= instruction;
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Randomized bench for mips_run_monitor: two instances (different timeout and
// trace depth) share stimulus and are checked against a run-level reference model.
module tb_mips_run_monitor;

    localparam int RC   = 2;
    localparam int HR   = 3;
    localparam int TO_A = 12;
    localparam int TO_B = 6;
    localparam int DP_A = 8;
    localparam int DP_B = 4;
    localparam int NS   = 14;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] pc;
    logic [31:0] instr;

    logic        cpu_reset_a, running_a, done_a;
    logic [1:0]  status_a, state_a;
    logic [31:0] cycle_count_a, trace_pc_a, trace_instr_a;
    logic [2:0]  tr_addr_a;
    logic [3:0]  trace_count_a;

    logic        cpu_reset_b, running_b, done_b;
    logic [1:0]  status_b, state_b;
    logic [31:0] cycle_count_b, trace_pc_b, trace_instr_b;
    logic [1:0]  tr_addr_b;
    logic [2:0]  trace_count_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] pcs [NS];
    logic [31:0] ins [NS];

    mips_run_monitor #(
        .DATA_W(32), .RESET_CYCLES(RC), .TIMEOUT(TO_A), .HALT_REPEAT(HR), .TRACE_DEPTH(DP_A)
    ) u_dut_a (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .PC(pc), .instruction(instr),
        .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a), .status(status_a),
        .cycle_count(cycle_count_a), .trace_addr(tr_addr_a),
        .trace_pc(trace_pc_a), .trace_instr(trace_instr_a),
        .trace_count(trace_count_a), .fsm_state(state_a)
    );

    mips_run_monitor #(
        .DATA_W(32), .RESET_CYCLES(RC), .TIMEOUT(TO_B), .HALT_REPEAT(HR), .TRACE_DEPTH(DP_B)
    ) u_dut_b (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .PC(pc), .instruction(instr),
        .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b), .status(status_b),
        .cycle_count(cycle_count_b), .trace_addr(tr_addr_b),
        .trace_pc(trace_pc_b), .trace_instr(trace_instr_b),
        .trace_count(trace_count_b), .fsm_state(state_b)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the sample list applying the run-ending rules in order.
    function automatic void run_model(input int timeout, input int abort_at,
                                      output int end_j, output int st, output int cnt);
        logic halt;
        cnt   = 0;
        end_j = NS;
        st    = 0;
        for (int j = 0; j < NS; j++) begin
            if (j == abort_at) begin
                end_j = j; st = 3; return;
            end
            cnt++;
            halt = (j >= HR);
            if (halt)
                for (int k = 1; k <= HR; k++)
                    if (pcs[j-k] != pcs[j]) halt = 1'b0;
            if (halt) begin
                end_j = j; st = 1; return;
            end
            if (cnt == timeout) begin
                end_j = j; st = 2; return;
            end
        end
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, "_cpu_reset_a"}, cpu_reset_a, 1);
        check({tag, "_running_a"}, running_a, 0);
        check({tag, "_done_a"}, done_a, 0);
        check({tag, "_status_a"}, status_a, 0);
        check({tag, "_count_a"}, cycle_count_a, 0);
        check({tag, "_tcount_a"}, trace_count_a, 0);
        check({tag, "_tpc_a"}, trace_pc_a, 0);
        check({tag, "_tin_a"}, trace_instr_a, 0);
        check({tag, "_cpu_reset_b"}, cpu_reset_b, 1);
        check({tag, "_done_b"}, done_b, 0);
        check({tag, "_count_b"}, cycle_count_b, 0);
        check({tag, "_tcount_b"}, trace_count_b, 0);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_cpu_reset_a", cpu_reset_a, 1);
        check("start_done_a", done_a, 0);
        check("start_status_a", status_a, 0);
        check("start_count_a", cycle_count_a, 0);
        check("start_tcount_a", trace_count_a, 0);
        check("start_done_b", done_b, 0);
        check("start_status_b", status_b, 0);
        check("start_tcount_b", trace_count_b, 0);
    endtask

    task automatic do_run(input int abort_at);
        int end_a, st_a, cnt_a, end_b, st_b, cnt_b;
        logic [31:0] exp_q_a[$], exp_iq_a[$], exp_q_b[$], exp_iq_b[$];
        run_model(TO_A, abort_at, end_a, st_a, cnt_a);
        run_model(TO_B, abort_at, end_b, st_b, cnt_b);

        start_run();
        for (int h = 0; h < RC; h++) begin
            tick();
            check("hold_cpu_reset_a", cpu_reset_a, (h == RC-1) ? 0 : 1);
            check("hold_running_a", running_a, (h == RC-1) ? 1 : 0);
            check("hold_cpu_reset_b", cpu_reset_b, (h == RC-1) ? 0 : 1);
        end

        for (int j = 0; j < NS; j++) begin
            pc    = pcs[j];
            instr = ins[j];
            abort = (j == abort_at);
            tick();
            abort = 1'b0;
            if (j < end_a) begin
                check("run_running_a", running_a, 1);
                check("run_count_a", cycle_count_a, 64'(j+1));
            end else begin
                check("end_done_a", done_a, 1);
                check("end_running_a", running_a, 0);
                check("end_cpu_reset_a", cpu_reset_a, 1);
            end
            if (j < end_b) begin
                check("run_running_b", running_b, 1);
                check("run_count_b", cycle_count_b, 64'(j+1));
            end else begin
                check("end_done_b", done_b, 1);
                check("end_running_b", running_b, 0);
                check("end_cpu_reset_b", cpu_reset_b, 1);
            end
            if (j >= end_a && j >= end_b) break;
        end

        check("final_status_a", status_a, 64'(st_a));
        check("final_count_a", cycle_count_a, 64'(cnt_a));
        check("final_status_b", status_b, 64'(st_b));
        check("final_count_b", cycle_count_b, 64'(cnt_b));

        // expected trace: the most recent samples, oldest first
        for (int j = 0; j < cnt_a; j++) begin
            exp_q_a.push_back(pcs[j]);
            exp_iq_a.push_back(ins[j]);
            if (exp_q_a.size() > DP_A) begin
                void'(exp_q_a.pop_front());
                void'(exp_iq_a.pop_front());
            end
        end
        for (int j = 0; j < cnt_b; j++) begin
            exp_q_b.push_back(pcs[j]);
            exp_iq_b.push_back(ins[j]);
            if (exp_q_b.size() > DP_B) begin
                void'(exp_q_b.pop_front());
                void'(exp_iq_b.pop_front());
            end
        end
        check("tcount_a", trace_count_a, 64'(exp_q_a.size()));
        check("tcount_b", trace_count_b, 64'(exp_q_b.size()));

        for (int a = 0; a < DP_A; a++) begin
            tr_addr_a = 3'(a);
            tr_addr_b = 2'(a);
            tick();
            check("trace_pc_a", trace_pc_a, (a < exp_q_a.size()) ? 64'(exp_q_a[a]) : 64'd0);
            check("trace_in_a", trace_instr_a, (a < exp_iq_a.size()) ? 64'(exp_iq_a[a]) : 64'd0);
            if (a < DP_B) begin
                check("trace_pc_b", trace_pc_b, (a < exp_q_b.size()) ? 64'(exp_q_b[a]) : 64'd0);
                check("trace_in_b", trace_instr_b, (a < exp_iq_b.size()) ? 64'(exp_iq_b[a]) : 64'd0);
            end
        end
    endtask

    task automatic fill_random();
        pcs[0] = 32'($urandom_range(0, 15)) * 32'd4;
        ins[0] = $urandom;
        for (int j = 1; j < NS; j++) begin
            pcs[j] = ($urandom_range(0, 1) == 0) ? pcs[j-1] : 32'($urandom_range(0, 15)) * 32'd4;
            ins[j] = $urandom;
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        pc        = '0;
        instr     = '0;
        tr_addr_a = '0;
        tr_addr_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_reset("por");

        // halt on jump-to-self; instance b halts on its timeout sample too
        for (int j = 0; j < NS; j++) begin
            pcs[j] = (j < 2) ? 32'(j * 4) : ((j < 6) ? 32'd8 : 32'(j * 4));
            ins[j] = 32'h1000_0000 + 32'(j);
        end
        do_run(-1);

        // abort on the halting edge takes priority and drops that sample
        do_run(5);

        // timeout with an incrementing PC; trace wraps on both depths
        for (int j = 0; j < NS; j++) begin
            pcs[j] = 32'(j * 4);
            ins[j] = 32'hAB00_0000 ^ 32'(j * 17);
        end
        do_run(-1);

        // restart from DONE, abort while the core is still held in reset
        start_run();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("hold_abort_done_a", done_a, 1);
        check("hold_abort_status_a", status_a, 3);
        check("hold_abort_count_a", cycle_count_a, 0);
        check("hold_abort_cpu_reset_a", cpu_reset_a, 1);
        check("hold_abort_status_b", status_b, 3);

        // asynchronous reset in the middle of a run
        start_run();
        repeat (RC) tick();
        for (int j = 0; j < 4; j++) begin
            pc = 32'(j * 4);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle_reset("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) tick();
        check("post_rst_idle_cpu_reset_a", cpu_reset_a, 1);
        check("post_rst_idle_running_a", running_a, 0);

        for (int r = 0; r < 30; r++) begin
            fill_random();
            do_run(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS-1)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
